fp_alu_arbiter: RTL and testbench
=================================

Name: fp_alu_arbiter

Overview:
- Shares one 32-bit IEEE-754 single-precision ALU between two requesters.
- ALU ports: A, B, operation[2:0], Result, Exception, Overflow, Underflow.
- Arbitrates requests round-robin, latches operands, holds them stable on the ALU for a programmable settle/latency window, then captures the result and flags into a response register with a valid/ready handshake.
- Sits between the command sources and the ALU instance in the FPU subsystem.

Parameters:
- ALU_LATENCY, 2, cycles operands are held on the ALU before capture; legal range 1..15.
- CNT_W, 4, width of the latency counter; must hold ALU_LATENCY.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 accepted (handshake when valid&ready)
- req0_a  in  32  requester 0 operand A
- req0_b  in  32  requester 0 operand B
- req0_op  in  3  requester 0 opcode: 000 add, 001 sub, 010 mul, 011 div
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1
- alu_a  out  32  to ALU A
- alu_b  out  32  to ALU B
- alu_op  out  3  to ALU operation
- alu_result  in  32  from ALU Result
- alu_exception  in  1  from ALU Exception
- alu_overflow  in  1  from ALU Overflow
- alu_underflow  in  1  from ALU Underflow
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester index of the response
- rsp_result  out  32  captured result
- rsp_flags  out  3  {exception, overflow, underflow}
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n low):
  - Outputs: rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_id=0, alu_a=0, alu_b=0, alu_op=000, busy=0.
  - State and pointers: FSM=IDLE, last_grant=1 (so requester 0 wins first), counter=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = round-robin over the valid requesters. If only one is valid, it wins. If both are valid, the one not equal to last_grant wins.
  - reqN_ready is combinational, high only for the granted requester and only in IDLE; both readys are low in every other state.
  - On the handshake edge: latch a/b/op into the ALU drive registers, latch rsp_id, set last_grant, and go to EXEC with counter=ALU_LATENCY-1.
  - Illegal opcode (op[2]=1): skip EXEC and go directly to RESP with rsp_result=32'h7FC00000 (qNaN) and rsp_flags=3'b100. The ALU drive registers are not updated.
- EXEC:
  - alu_a/alu_b/alu_op are held constant.
  - The counter decrements each cycle. In the cycle where counter==0, capture alu_result and the flags into the rsp registers, then go to RESP.
  - Latency: with the handshake at edge 0, rsp_valid first goes high after edge ALU_LATENCY.
- RESP:
  - rsp_valid=1 and the rsp_* values are stable until rsp_valid&rsp_ready.
  - On that edge: rsp_valid=0 and the FSM returns to IDLE.
  - No new grant in the same cycle: there is at least one IDLE cycle between commands.
- ALU drive registers keep their last values in IDLE and RESP; they are never cleared except by reset.
- Requester inputs are sampled only on the handshake edge; changes on the operand inputs at other times are ignored.
- Reset asserted mid-EXEC or mid-RESP: the in-flight command is dropped, no response is produced, and all outputs take their reset values immediately.
- A requester that deasserts valid before ready is not granted. Pointer fairness is preserved because last_grant only updates on a handshake.

Optional Feature:
- Macro: FP_ALU_STICKY_FLAGS_EN.
- Defined:
  - Adds port clr_sticky (in, 1) and port sticky_flags (out, 3), reset 0.
  - On each capture: sticky_flags <= (clr_sticky ? 0 : sticky_flags) | captured_flags.
  - Otherwise clr_sticky clears it.
  - Illegal-op responses also set bit 2.
- Undefined: neither port exists and no sticky logic is present.

Decomposition:
- Package fp_alu_pkg:
  - opcode constants OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b010, OP_DIV=3'b011;
  - QNAN=32'h7FC00000;
  - FSM state encodings IDLE/EXEC/RESP;
  - flag bit indices FLG_EXC=2, FLG_OVF=1, FLG_UNF=0.
- One natural sub-module: rr_arb2, a two-input round-robin grant with a last_grant pointer. The FSM and datapath stay in the top.

Test Plan:
- Bench uses a stub ALU model.
- Basic add:
  - Stimulus: req0 with a=32'h411CCCCD (9.8), b=32'h4089999A (4.3), op=000; stub returns 32'h4161999A with flags 000; ALU_LATENCY=2.
  - Required: req0_ready high in IDLE; rsp_valid rises 2 edges after the handshake; rsp_result=32'h4161999A; rsp_id=0; flags=000.
- Contention:
  - Stimulus: req0 and req1 both valid continuously for 4 commands.
  - Required: grants alternate 0,1,0,1 and rsp_id follows the same order.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles after rsp_valid.
  - Required: rsp_result/flags stable, busy=1, both readys 0; on release, 1 cycle to IDLE.
- Illegal op:
  - Stimulus: req1 op=3'b101.
  - Required: rsp_valid 1 edge after the handshake; result 32'h7FC00000; flags 100; alu_op unchanged.
- Flag capture:
  - Stimulus: stub asserts overflow during the capture cycle only (mul).
  - Required: rsp_flags=010. With FP_ALU_STICKY_FLAGS_EN: sticky_flags=010 persists until clr_sticky.
- Reset mid-EXEC:
  - Stimulus: drop rst_n one cycle after the handshake.
  - Required: rsp_valid never asserts; alu_a=0, alu_op=000; after release, requester 0 wins first.

Source files
------------

// File: rtl/fp_alu_pkg.sv
// Shared constants and types for the FP ALU arbiter.
package fp_alu_pkg;

    localparam logic [2:0]  OP_ADD = 3'b000;
    localparam logic [2:0]  OP_SUB = 3'b001;
    localparam logic [2:0]  OP_MUL = 3'b010;
    localparam logic [2:0]  OP_DIV = 3'b011;

    localparam logic [31:0] QNAN   = 32'h7FC00000;

    localparam int FLG_EXC = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_UNF = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } cmd_t;

    typedef struct packed {
        logic        id;
        logic [31:0] result;
        logic [2:0]  flags;
    } rsp_t;

    // Opcodes with bit 2 set have no ALU operation behind them.
    function automatic logic op_illegal(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/fp_alu_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves only on an accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    output logic       gnt_id,
    output logic       gnt_any
);

    logic last_grant;

    // Lone requester wins; on a tie the one not served last wins.
    always_comb begin
        gnt_any = |req;
        if (&req) gnt_id = ~last_grant;
        else      gnt_id = req[1];
    end

    // Reset to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   last_grant <= 1'b1;
        else if (upd) last_grant <= gnt_id;
    end

endmodule

// File: rtl/fp_alu_arbiter.sv
// Shares one single-precision FP ALU between two requesters.
// Optional: FP_ALU_STICKY_FLAGS_EN adds clr_sticky / sticky_flags.
module fp_alu_arbiter
    import fp_alu_pkg::*;
#(
    parameter int ALU_LATENCY = 2,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_exception,
    input  logic        alu_overflow,
    input  logic        alu_underflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [2:0]  rsp_flags,
    output logic        busy
`ifdef FP_ALU_STICKY_FLAGS_EN
   ,input  logic        clr_sticky,
    output logic [2:0]  sticky_flags
`endif
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ALU_LATENCY - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    cmd_t             cmd_sel, drv;
    rsp_t             rsp;
    logic             gnt_id, gnt_any, hs, capture, sel_illegal;
    logic [2:0]       cap_flags;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1_valid, req0_valid}),
        .upd     (hs),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    assign cmd_sel     = gnt_id ? cmd_t'{req1_a, req1_b, req1_op}
                                : cmd_t'{req0_a, req0_b, req0_op};
    assign sel_illegal = op_illegal(cmd_sel.op);
    assign hs          = (state == IDLE) && gnt_any;
    assign capture     = (state == EXEC) && (cnt == '0);

    assign cap_flags[FLG_EXC] = alu_exception;
    assign cap_flags[FLG_OVF] = alu_overflow;
    assign cap_flags[FLG_UNF] = alu_underflow;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and grant handshake; ready is only offered from IDLE.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = hs && !gnt_id;
                req1_ready = hs &&  gnt_id;
                if (hs) state_nxt = sel_illegal ? RESP : EXEC;
            end
            EXEC:    if (capture)   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand drive, latency counter and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv <= '0;
            rsp <= '0;
            cnt <= '0;
        end else begin
            if (hs) begin
                rsp.id <= gnt_id;
                if (sel_illegal) begin
                    rsp.result <= QNAN;
                    rsp.flags  <= 3'b100;
                end else begin
                    drv <= cmd_sel;
                    cnt <= LAT_M1;
                end
            end
            if (state == EXEC) begin
                if (capture) begin
                    rsp.result <= alu_result;
                    rsp.flags  <= cap_flags;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

`ifdef FP_ALU_STICKY_FLAGS_EN
    // Accumulate flags across responses until software clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 sticky_flags <= '0;
        else if (capture)           sticky_flags <= (clr_sticky ? 3'b000 : sticky_flags) | cap_flags;
        else if (hs && sel_illegal) sticky_flags <= (clr_sticky ? 3'b000 : sticky_flags) | 3'b100;
        else if (clr_sticky)        sticky_flags <= '0;
    end
`endif

    assign alu_a      = drv.a;
    assign alu_b      = drv.b;
    assign alu_op     = drv.op;
    assign rsp_valid  = (state == RESP);
    assign rsp_id     = rsp.id;
    assign rsp_result = rsp.result;
    assign rsp_flags  = rsp.flags;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Directed bench for fp_alu_arbiter with a stub ALU.
module tb_fp_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_exception, alu_overflow, alu_underflow;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flags;
    logic        stub_exc, stub_ovf, stub_unf;
`ifdef FP_ALU_STICKY_FLAGS_EN
    logic        clr_sticky;
    logic [2:0]  sticky_flags;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_alu_arbiter #(.ALU_LATENCY(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_exception(alu_exception),
        .alu_overflow(alu_overflow), .alu_underflow(alu_underflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
`ifdef FP_ALU_STICKY_FLAGS_EN
       ,.clr_sticky(clr_sticky), .sticky_flags(sticky_flags)
`endif
    );

    // Stub ALU: the known add vector, otherwise an integer sum of the operands.
    always_comb begin
        if (alu_a == 32'h411CCCCD && alu_b == 32'h4089999A && alu_op == 3'b000)
            alu_result = 32'h4161999A;
        else
            alu_result = alu_a + alu_b;
        alu_exception = stub_exc;
        alu_overflow  = stub_ovf;
        alu_underflow = stub_unf;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_rsp(input int maxc);
        int n = 0;
        while (!rsp_valid && n < maxc) begin
            cyc();
            n++;
        end
        if (!rsp_valid) chk("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rsp_ready = 0; stub_exc = 0; stub_ovf = 0; stub_unf = 0;
`ifdef FP_ALU_STICKY_FLAGS_EN
        clr_sticky = 0;
`endif
        #1;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_flags", {29'b0, rsp_flags}, 0);
        chk("rst_rsp_id", {31'b0, rsp_id}, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", {29'b0, alu_op}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Basic add from requester 0.
        req0_valid = 1; req0_a = 32'h411CCCCD; req0_b = 32'h4089999A; req0_op = 3'b000;
        #1;
        chk("add_ready0", {31'b0, req0_ready}, 1);
        chk("add_ready1", {31'b0, req1_ready}, 0);
        @(posedge clk); @(negedge clk);
        req0_valid = 0;
        chk("add_e0_valid", {31'b0, rsp_valid}, 0);
        chk("add_e0_busy", {31'b0, busy}, 1);
        chk("add_e0_ready0", {31'b0, req0_ready}, 0);
        chk("add_alu_a", alu_a, 32'h411CCCCD);
        chk("add_alu_b", alu_b, 32'h4089999A);
        cyc();
        chk("add_e1_valid", {31'b0, rsp_valid}, 0);
        cyc();
        chk("add_e2_valid", {31'b0, rsp_valid}, 1);
        chk("add_result", rsp_result, 32'h4161999A);
        chk("add_id", {31'b0, rsp_id}, 0);
        chk("add_flags", {29'b0, rsp_flags}, 0);
        ack();
        chk("add_done_valid", {31'b0, rsp_valid}, 0);
        chk("add_done_busy", {31'b0, busy}, 0);

        // Illegal opcode from requester 1 bypasses the ALU.
        req1_valid = 1; req1_a = 32'h12345678; req1_b = 32'h9ABCDEF0; req1_op = 3'b101;
        #1;
        chk("ill_ready1", {31'b0, req1_ready}, 1);
        @(posedge clk); @(negedge clk);
        req1_valid = 0;
        chk("ill_valid", {31'b0, rsp_valid}, 1);
        chk("ill_result", rsp_result, 32'h7FC00000);
        chk("ill_flags", {29'b0, rsp_flags}, 3'b100);
        chk("ill_id", {31'b0, rsp_id}, 1);
        chk("ill_alu_op", {29'b0, alu_op}, 0);
        chk("ill_alu_a", alu_a, 32'h411CCCCD);
`ifdef FP_ALU_STICKY_FLAGS_EN
        chk("ill_sticky", {29'b0, sticky_flags}, 3'b100);
`endif
        ack();
`ifdef FP_ALU_STICKY_FLAGS_EN
        clr_sticky = 1; cyc(); clr_sticky = 0;
        chk("sticky_clr0", {29'b0, sticky_flags}, 0);
`endif

        // Contention: both requesters valid for four commands.
        req0_a = 100;  req0_b = 23; req0_op = 3'b000;
        req1_a = 1000; req1_b = 7;  req1_op = 3'b010;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready1", {31'b0, req1_ready}, i % 2);
            chk("rr_ready0", {31'b0, req0_ready}, 1 - (i % 2));
            @(posedge clk); @(negedge clk);
            wait_rsp(8);
            chk("rr_id", {31'b0, rsp_id}, i % 2);
            chk("rr_result", rsp_result, (i % 2) ? 32'd1007 : 32'd123);
            ack();
        end
        req0_valid = 0; req1_valid = 0;
        cyc();

        // Backpressure: response held while the consumer stalls.
        req0_valid = 1; req0_a = 5; req0_b = 6; req0_op = 3'b001;
        #1;
        @(posedge clk); @(negedge clk);
        req0_valid = 0; req1_valid = 1; req1_op = 3'b000;
        wait_rsp(8);
        for (int i = 0; i < 5; i++) begin
            req0_a = 32'hDEAD0000 + i;
            chk("bp_result", rsp_result, 32'd11);
            chk("bp_flags", {29'b0, rsp_flags}, 0);
            chk("bp_busy", {31'b0, busy}, 1);
            chk("bp_readys", {30'b0, req1_ready, req0_ready}, 0);
            cyc();
        end
        chk("bp_still_valid", {31'b0, rsp_valid}, 1);
        rsp_ready = 1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 0;
        chk("bp_rel_valid", {31'b0, rsp_valid}, 0);
        chk("bp_rel_busy", {31'b0, busy}, 0);
        chk("bp_rel_ready1", {31'b0, req1_ready}, 1);
        req1_valid = 0;
        cyc();

        // Flag capture: exception outside capture is ignored, overflow at capture is kept.
        req1_valid = 1; req1_a = 3; req1_b = 4; req1_op = 3'b010;
        #1;
        @(posedge clk); @(negedge clk);
        req1_valid = 0; stub_exc = 1;
        cyc();
        stub_exc = 0; stub_ovf = 1;
        cyc();
        stub_ovf = 0;
        chk("flg_valid", {31'b0, rsp_valid}, 1);
        chk("flg_flags", {29'b0, rsp_flags}, 3'b010);
        chk("flg_result", rsp_result, 32'd7);
        chk("flg_id", {31'b0, rsp_id}, 1);
`ifdef FP_ALU_STICKY_FLAGS_EN
        chk("flg_sticky", {29'b0, sticky_flags}, 3'b010);
`endif
        ack();
        cyc();
`ifdef FP_ALU_STICKY_FLAGS_EN
        chk("flg_sticky_hold", {29'b0, sticky_flags}, 3'b010);
        clr_sticky = 1; cyc(); clr_sticky = 0;
        chk("flg_sticky_clr", {29'b0, sticky_flags}, 0);
`endif

        // Reset mid-EXEC drops the command.
        req0_valid = 1; req0_a = 9; req0_b = 9; req0_op = 3'b000;
        #1;
        @(posedge clk); @(negedge clk);
        req0_valid = 0;
        chk("rx_alu_a_pre", alu_a, 32'd9);
        @(posedge clk); @(negedge clk);
        rst_n = 0;
        #1;
        chk("rx_alu_a", alu_a, 0);
        chk("rx_alu_op", {29'b0, alu_op}, 0);
        chk("rx_valid", {31'b0, rsp_valid}, 0);
        chk("rx_busy", {31'b0, busy}, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rx_hold_valid", {31'b0, rsp_valid}, 0);
        end
        rst_n = 1;
        cyc();
        chk("rx_after_valid", {31'b0, rsp_valid}, 0);
        req0_valid = 1; req1_valid = 1; req0_a = 1; req0_b = 2; req0_op = 3'b000;
        #1;
        chk("rx_first_ready0", {31'b0, req0_ready}, 1);
        chk("rx_first_ready1", {31'b0, req1_ready}, 0);
        @(posedge clk); @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        wait_rsp(8);
        chk("rx_first_id", {31'b0, rsp_id}, 0);
        chk("rx_first_result", rsp_result, 32'd3);
        ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
